simd_int_alu_pipe: RTL and testbench

- Pipelined, parametrised SIMT integer ALU: `NUM_LANES` copies of the scalar `int_alu` evaluate one warp operation per cycle behind a valid/ready handshake.
- Each result carries a tag, the active mask and aggregate lane flags.
- Sits between operand collect and writeback in the execute stage and replaces the purely combinational SIMD ALU.
- Adds backpressure, flush, masked-lane zeroing and registered outputs.

---
 rtl/pkg_opengpu.sv | 28 ++
 rtl/int_alu.sv | 42 ++++
 rtl/simd_int_alu_pipe.sv | 130 +++++++++++++
 tb/tb_simd_int_alu_pipe.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_opengpu.sv
// Shared opengpu execute-stage types: ALU opcodes, default warp/lane sizes
// and the aggregate lane-flag bundle carried with SIMD results.
package pkg_opengpu;

  localparam int WARP_SIZE  = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic any_zero;
    logic all_zero;
    logic any_neg;
    logic all_neg;
  } simd_flags_t;

endpackage

// File: rtl/int_alu.sv
// Scalar integer ALU for one lane; wrap-around arithmetic, shifts use the low log2(WIDTH) bits of b.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
module int_alu
  import pkg_opengpu::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = WIDTH'($signed(a) >>> shamt);
      ALU_SLT:  result = WIDTH'($signed(a) < $signed(b));
      ALU_SLTU: result = WIDTH'(a < b);
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign neg  = result[WIDTH-1];

endmodule

// File: rtl/simd_int_alu_pipe.sv
// SIMT integer ALU: NUM_LANES int_alu lanes, masked results and lane-flag aggregates, elastic register pipe.
// Latency: PIPE_STAGES cycles from accept to out_valid, 1 op/cycle sustained.
// Backpressure: bubble-collapsing valid/ready; in_ready follows out_ready combinationally only when the pipe is full.
module simd_int_alu_pipe
  import pkg_opengpu::*;
#(
  parameter int NUM_LANES   = WARP_SIZE,
  parameter int LANE_WIDTH  = DATA_WIDTH,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_WIDTH   = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  alu_op_t                         in_op,
  input  logic [NUM_LANES-1:0]            in_mask,
  input  logic [TAG_WIDTH-1:0]            in_tag,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] in_a,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] in_b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*LANE_WIDTH-1:0] out_result,
  output logic [NUM_LANES-1:0]            out_mask,
  output logic [TAG_WIDTH-1:0]            out_tag,
  output logic [NUM_LANES-1:0]            out_zero_flags,
  output logic [NUM_LANES-1:0]            out_neg_flags,
  output logic                            out_any_zero,
  output logic                            out_all_zero,
  output logic                            out_any_neg,
  output logic                            out_all_neg,
  output logic                            busy
);

  localparam int DW = NUM_LANES * LANE_WIDTH;

  typedef struct packed {
    logic [DW-1:0]        result;
    logic [NUM_LANES-1:0] zero_flags;
    logic [NUM_LANES-1:0] neg_flags;
    logic [NUM_LANES-1:0] mask;
    logic [TAG_WIDTH-1:0] tag;
    simd_flags_t          agg;
  } stage_t;

  logic [DW-1:0]        lane_res;
  logic [NUM_LANES-1:0] lane_zero;
  logic [NUM_LANES-1:0] lane_neg;
  stage_t               new_dat;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    int_alu #(.WIDTH(LANE_WIDTH)) u_alu (
      .op     (in_op),
      .a      (in_a[i*LANE_WIDTH +: LANE_WIDTH]),
      .b      (in_b[i*LANE_WIDTH +: LANE_WIDTH]),
      .result (lane_res[i*LANE_WIDTH +: LANE_WIDTH]),
      .zero   (lane_zero[i]),
      .neg    (lane_neg[i])
    );
  end

  // all_* start true only if some lane is active, so an empty mask yields all-zero aggregates
  always_comb begin
    new_dat              = '0;
    new_dat.mask         = in_mask;
    new_dat.tag          = in_tag;
    new_dat.agg.all_zero = (in_mask != '0);
    new_dat.agg.all_neg  = (in_mask != '0);
    for (int i = 0; i < NUM_LANES; i++) begin
      if (in_mask[i]) begin
        new_dat.result[i*LANE_WIDTH +: LANE_WIDTH] = lane_res[i*LANE_WIDTH +: LANE_WIDTH];
        new_dat.zero_flags[i] = lane_zero[i];
        new_dat.neg_flags[i]  = lane_neg[i];
        new_dat.agg.any_zero  = new_dat.agg.any_zero | lane_zero[i];
        new_dat.agg.all_zero  = new_dat.agg.all_zero & lane_zero[i];
        new_dat.agg.any_neg   = new_dat.agg.any_neg | lane_neg[i];
        new_dat.agg.all_neg   = new_dat.agg.all_neg & lane_neg[i];
      end
    end
  end

  stage_t                 stage_dat [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] stage_vld;
  logic [PIPE_STAGES:0]   stage_ld;
  logic                   accept;

  // stage_ld[k]: stage k may take new contents this cycle; the top bit is the output handshake
  always_comb begin
    stage_ld              = '0;
    stage_ld[PIPE_STAGES] = out_ready;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      stage_ld[k] = !stage_vld[k] || stage_ld[k+1];
    end
  end

  assign in_ready = stage_ld[0] && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      stage_vld <= '0;
    end else begin
      if (stage_ld[0]) stage_vld[0] <= accept;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (stage_ld[k]) stage_vld[k] <= stage_vld[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) stage_dat[0] <= new_dat;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      if (stage_ld[k]) stage_dat[k] <= stage_dat[k-1];
    end
  end

  assign out_valid      = stage_vld[PIPE_STAGES-1];
  assign out_result     = stage_dat[PIPE_STAGES-1].result;
  assign out_mask       = stage_dat[PIPE_STAGES-1].mask;
  assign out_tag        = stage_dat[PIPE_STAGES-1].tag;
  assign out_zero_flags = stage_dat[PIPE_STAGES-1].zero_flags;
  assign out_neg_flags  = stage_dat[PIPE_STAGES-1].neg_flags;
  assign out_any_zero   = stage_dat[PIPE_STAGES-1].agg.any_zero;
  assign out_all_zero   = stage_dat[PIPE_STAGES-1].agg.all_zero;
  assign out_any_neg    = stage_dat[PIPE_STAGES-1].agg.any_neg;
  assign out_all_neg    = stage_dat[PIPE_STAGES-1].agg.all_neg;
  assign busy           = |stage_vld;

endmodule

// File: tb/tb_simd_int_alu_pipe.sv
// Scoreboard bench for simd_int_alu_pipe over three configurations (32 lanes/2 stages, 8 lanes/1 stage, 32 lanes/4 stages).
// Stimulus pushes model results into a queue; a negedge monitor pops and compares on every output handshake.
module tb_simd_int_alu_pipe;
  import pkg_opengpu::*;

  localparam int W    = 32;
  localparam int ML   = 32;
  localparam int NCFG = 3;

  typedef struct {
    logic [ML*W-1:0] res;
    logic [ML-1:0]   mask;
    logic [ML-1:0]   zf;
    logic [ML-1:0]   nf;
    logic [4:0]      tag;
    logic [3:0]      agg;
    int              acc;
    bit              lat;
  } exp_t;

  function automatic int nl_of(input int c);
    return (c == 1) ? 8 : 32;
  endfunction

  function automatic int ps_of(input int c);
    return (c == 0) ? 2 : ((c == 1) ? 1 : 4);
  endfunction

  logic            clk;
  logic            rst_n, flush, in_valid, out_ready;
  alu_op_t         in_op;
  logic [ML-1:0]   in_mask;
  logic [4:0]      in_tag;
  logic [ML*W-1:0] in_a, in_b;

  logic            ir     [NCFG];
  logic            o_vld  [NCFG];
  logic            o_busy [NCFG];
  logic [ML*W-1:0] o_res  [NCFG];
  logic [ML-1:0]   o_mask [NCFG];
  logic [ML-1:0]   o_zf   [NCFG];
  logic [ML-1:0]   o_nf   [NCFG];
  logic [4:0]      o_tag  [NCFG];
  logic [3:0]      o_agg  [NCFG];

  int   cur;
  int   cyc = 0;
  int   n_checks;
  int   n_pass;
  bit   mon_en, prev_stall, bp_done;
  exp_t q[$];
  logic [ML*W-1:0] prev_res;
  logic [4:0]      prev_tag;
  logic [ML-1:0]   prev_mask;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int NL = nl_of(g);
    localparam int PS = ps_of(g);
    logic [NL*W-1:0] res;
    logic [NL-1:0]   om, zf, nf;
    logic [4:0]      tg;
    logic            az, alz, an, aln, vld, rdy, bsy;

    simd_int_alu_pipe #(
      .NUM_LANES  (NL),
      .LANE_WIDTH (W),
      .PIPE_STAGES(PS),
      .TAG_WIDTH  (5)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .in_valid      (in_valid && (cur == g)),
      .in_ready      (rdy),
      .in_op         (in_op),
      .in_mask       (in_mask[NL-1:0]),
      .in_tag        (in_tag),
      .in_a          (in_a[NL*W-1:0]),
      .in_b          (in_b[NL*W-1:0]),
      .out_valid     (vld),
      .out_ready     (out_ready),
      .out_result    (res),
      .out_mask      (om),
      .out_tag       (tg),
      .out_zero_flags(zf),
      .out_neg_flags (nf),
      .out_any_zero  (az),
      .out_all_zero  (alz),
      .out_any_neg   (an),
      .out_all_neg   (aln),
      .busy          (bsy)
    );

    assign ir[g]     = rdy;
    assign o_vld[g]  = vld;
    assign o_busy[g] = bsy;
    assign o_res[g]  = (ML*W)'(res);
    assign o_mask[g] = ML'(om);
    assign o_zf[g]   = ML'(zf);
    assign o_nf[g]   = ML'(nf);
    assign o_tag[g]  = tg;
    assign o_agg[g]  = {az, alz, an, aln};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s (cfg %0d, cycle %0d): got %0h, expected %0h", nm, cur, cyc, act, want);
  endtask

  // Reference lane semantics: plain modular arithmetic, shift distance is b mod 32.
  function automatic logic [W-1:0] ref_op(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned sh;
    sh = b % W;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return W'($signed(a) >>> sh);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      ALU_SLTU: return (a < b) ? W'(1) : W'(0);
      default:  return W'(0);
    endcase
  endfunction

  function automatic exp_t model(input alu_op_t op, input logic [ML-1:0] mask, input logic [4:0] tag,
                                 input logic [ML*W-1:0] a, input logic [ML*W-1:0] b, input int nl);
    exp_t e;
    int nact, nz, nn;
    logic [W-1:0] r;
    nact = 0; nz = 0; nn = 0;
    e.res = '0; e.mask = '0; e.zf = '0; e.nf = '0;
    e.tag = tag; e.acc = 0; e.lat = 1'b0;
    for (int i = 0; i < nl; i++) begin
      e.mask[i] = mask[i];
      if (mask[i]) begin
        r = ref_op(op, a[i*W +: W], b[i*W +: W]);
        e.res[i*W +: W] = r;
        e.zf[i] = (r == '0);
        e.nf[i] = r[W-1];
        nact++;
        if (r == '0) nz++;
        if (r[W-1]) nn++;
      end
    end
    e.agg = {nz > 0, (nact > 0) && (nz == nact), nn > 0, (nact > 0) && (nn == nact)};
    return e;
  endfunction

  task automatic issue(input alu_op_t op, input logic [ML-1:0] mask, input logic [4:0] tag,
                       input logic [ML*W-1:0] a, input logic [ML*W-1:0] b, input bit lat);
    exp_t e;
    int   tries;
    bit   taken;
    tries = 0;
    taken = 1'b0;
    e = model(op, mask, tag, a, b, nl_of(cur));
    e.lat = lat;
    in_op = op; in_mask = mask; in_tag = tag; in_a = a; in_b = b; in_valid = 1'b1;
    while (!taken && tries < 200) begin
      @(negedge clk);
      if (ir[cur]) begin
        e.acc = cyc + 1;
        taken = 1'b1;
      end
      @(posedge clk);
      tries++;
    end
    if (taken) q.push_back(e);
    #1 in_valid = 1'b0;
    chk("issue accepted", 64'(taken), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || o_vld[cur]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain pending ops", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops(output logic [ML*W-1:0] a, output logic [ML*W-1:0] b);
    for (int i = 0; i < ML; i++) begin
      a[i*W +: W] = $urandom;
      b[i*W +: W] = ($urandom_range(0, 3) == 0) ? a[i*W +: W] : W'($urandom);
    end
  endtask

  task automatic stream(input int n, input bit rnd_rdy);
    bp_done = 1'b0;
    fork
      begin
        logic [ML*W-1:0] a, b;
        for (int t = 0; t < n; t++) begin
          rand_ops(a, b);
          issue(alu_op_t'($urandom_range(0, 9)), ML'($urandom), 5'(t), a, b, 1'b0);
        end
        bp_done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!bp_done) begin
          out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : ((k % 4 == 0) || (k % 4 == 3));
          k++;
          @(posedge clk);
          #1;
        end
      end
    join
    drain();
  endtask

  // Monitor: in_ready against pipe occupancy, stall stability, and scoreboard pops on handshakes.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        chk("in_ready", 64'(ir[cur]),
            64'(!flush && !((q.size() == ps_of(cur)) && !out_ready)));
        if (flush) begin
          prev_stall = 1'b0;
        end else begin
          if (prev_stall) begin
            chk("stall out_valid held", 64'(o_vld[cur]), 64'd1);
            chk("stall payload held",
                64'({o_res[cur] == prev_res, o_tag[cur] == prev_tag, o_mask[cur] == prev_mask}), 64'd7);
          end
          if (o_vld[cur] && out_ready) begin
            if (q.size() == 0) begin
              chk("output with nothing pending", 64'(o_tag[cur]), 64'hFFFF);
            end else begin
              exp_t e;
              int   bad;
              bit   found;
              e = q.pop_front();
              bad = 0;
              found = 1'b0;
              for (int i = 0; i < ML; i++) begin
                if (!found && o_res[cur][i*W +: W] !== e.res[i*W +: W]) begin
                  bad = i;
                  found = 1'b1;
                end
              end
              chk("out_tag", 64'(o_tag[cur]), 64'(e.tag));
              chk($sformatf("out_result lane %0d", bad), 64'(o_res[cur][bad*W +: W]), 64'(e.res[bad*W +: W]));
              chk("out_mask", 64'(o_mask[cur]), 64'(e.mask));
              chk("out_zero_flags", 64'(o_zf[cur]), 64'(e.zf));
              chk("out_neg_flags", 64'(o_nf[cur]), 64'(e.nf));
              chk("aggregates {any_z,all_z,any_n,all_n}", 64'(o_agg[cur]), 64'(e.agg));
              if (e.lat) chk("latency", 64'(cyc - e.acc + 1), 64'(ps_of(cur)));
            end
          end
          prev_stall = o_vld[cur] && !out_ready;
          prev_res   = o_res[cur];
          prev_tag   = o_tag[cur];
          prev_mask  = o_mask[cur];
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time budget exceeded at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ML*W-1:0] a, b;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = ALU_ADD; in_mask = '0; in_tag = '0; in_a = '0; in_b = '0;
    cur = 0; n_checks = 0; n_pass = 0; mon_en = 1'b0; prev_stall = 1'b0; bp_done = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < NCFG; c++) begin
      chk("reset out_valid", 64'(o_vld[c]), 64'd0);
      chk("reset busy", 64'(o_busy[c]), 64'd0);
      chk("reset in_ready", 64'(ir[c]), 64'd1);
    end
    @(posedge clk);
    #1 mon_en = 1'b1;

    for (int c = 0; c < NCFG; c++) begin
      cur = c;
      for (int i = 0; i < ML; i++) begin
        a[i*W +: W] = W'(i);
        b[i*W +: W] = W'(1);
      end
      issue(ALU_ADD, '1, 5'd1, a, b, 1'b1);
      drain();
      stream(10, 1'b0);
      stream(20, 1'b1);
      a = '1;
      for (int i = 0; i < ML; i++) b[i*W +: W] = W'(1);
      issue(ALU_ADD, '1, 5'd6, a, b, 1'b1);
      drain();
    end

    cur = 0;
    for (int i = 0; i < ML; i++) begin
      a[i*W +: W] = W'(5);
      b[i*W +: W] = W'(5);
    end
    issue(ALU_SUB, 32'h0000_000F, 5'd2, a, b, 1'b1);
    drain();
    rand_ops(a, b);
    issue(alu_op_t'($urandom_range(0, 9)), '0, 5'd21, a, b, 1'b1);
    drain();

    // Fill, then kill with flush while a new op is offered.
    out_ready = 1'b0;
    rand_ops(a, b);
    issue(ALU_XOR, ML'($urandom), 5'd1, a, b, 1'b0);
    issue(ALU_OR, ML'($urandom), 5'd2, a, b, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_tag = 5'd9;
    @(posedge clk);
    q.delete();
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post-flush out_valid", 64'(o_vld[cur]), 64'd0);
    chk("post-flush busy", 64'(o_busy[cur]), 64'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(ALU_ADD, '1, 5'd3, a, b, 1'b1);
    drain();

    // Same again, killed by reset mid-stall.
    out_ready = 1'b0;
    issue(ALU_SLL, ML'($urandom), 5'd1, a, b, 1'b0);
    issue(ALU_SRA, ML'($urandom), 5'd2, a, b, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    q.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset out_valid", 64'(o_vld[cur]), 64'd0);
    chk("post-reset busy", 64'(o_busy[cur]), 64'd0);
    chk("post-reset in_ready", 64'(ir[cur]), 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    issue(ALU_SLTU, '1, 5'd3, a, b, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
